dmem_responder: RTL
===================

# dmem_responder

Data-memory responder that serves the byte-wide load/store requests issued by the MEM stage of the VLIW pipeline. It holds a 32-byte direct-mapped read cache in front of an internal byte-addressed backing store. It returns `hit` plus 8-bit read data combinationally in the request cycle on a hit, and stalls the requester with a fixed-latency refill FSM on a miss. Stores are write-through and acknowledged in one cycle.

## Interface
- MEM_AW, 8, backing-store address width; store holds 2^MEM_AW bytes
- MISS_LAT, 4, refill wait cycles (≥1)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- req_valid  input  1  request present this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address; bits [31:MEM_AW] ignored (aliasing)
- req_wdata  input  8  store data
- hit  output  1  request completes this cycle (read data valid / store accepted)
- rdata  output  8  load data, valid when hit && !req_we, else 0
- busy  output  1  refill in progress
- miss_count  output  16  number of refills started, wraps at 0xFFFF→0

## Operation
- Address split: offset = addr[1:0], index = addr[4:2] (8 lines × 4 bytes), tag = addr[MEM_AW-1:5].
- Per line: valid bit, tag, 4 data bytes.
- FSM states: IDLE, REFILL, FILL.
- IDLE, load, valid[index] && tag match: hit=1, rdata = line byte[offset]; no state change.
- IDLE, load, miss: hit=0; latch the line-aligned address; go to REFILL with cnt = MISS_LAT-1; miss_count += 1.
- REFILL: hit=0, busy=1; cnt decrements each cycle; at cnt==0 go to FILL.
- FILL: hit=0, busy=1; write 4 bytes from the backing store (latched address) into the line; set valid and tag; go to IDLE.
- IDLE, store: hit=1; backing store byte written at that edge. If the line is valid with matching tag, the cached byte is updated in the same edge. No allocate on store miss.
- In REFILL/FILL, every request gets hit=0. Stores are not performed. The requester must hold req_* stable until hit=1.
- If the request changes during a refill, the refill still completes for the latched address. The new request is evaluated in IDLE afterwards.
- req_valid=0: hit=0, rdata=0.
- Reset: all valid bits cleared; backing store byte i initialised to i[7:0]; state IDLE; cnt=0; miss_count=0; busy=0.
- Reset asserted mid-REFILL/FILL abandons the refill. The line stays invalid.

## Timing
- Load hit: 0-cycle latency; hit/rdata combinational from req_* and array state in the same cycle.
- Load miss presented in cycle t:
  - REFILL during t+1 … t+MISS_LAT.
  - FILL in t+MISS_LAT+1.
  - hit=1 in t+MISS_LAT+2.
  - Stall = MISS_LAT+2 cycles.
- Store: hit=1 in the cycle presented (IDLE). Data is visible to a load in the following cycle, whether via cache or via the store on a later refill.
- busy is registered from state: 1 in exactly the REFILL and FILL cycles.
- All outputs are 0 during and immediately after reset while req_valid=0.

## Test plan
- Reset, then load 0x13 at t: hit=0 for t…t+5 (MISS_LAT=4); hit=1, rdata=0x13 at t+6; miss_count=1.
- After the previous case, load 0x10, 0x11, 0x12 back-to-back: hit=1 each cycle, rdata=0x10/0x11/0x12; miss_count stays 1.
- Store 0xAB to 0x12 (cached line): hit=1 same cycle. Next-cycle load 0x12 gives hit=1, rdata=0xAB. Load 0x112 (aliases 0x12 with MEM_AW=8) also gives rdata=0xAB after the refill.
- Store 0x5C to 0x40 (uncached): hit=1, no refill, miss_count unchanged. Later load 0x40 misses, then returns 0x5C after 6 cycles.
- Conflict: load 0x04 (miss→0x04), then load 0x24 (same index, tag differs): second refill with miss_count=2, rdata=0x24. Reload 0x04 misses again.
- Assert reset in the 2nd REFILL cycle, release, re-present load 0x13: full 6-cycle miss again, busy=0 and miss_count=0 immediately after reset.

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage load/store request bus for dmem_responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        hit;
  logic [7:0]  rdata;
  logic        busy;
  logic [15:0] miss_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  hit, rdata, busy, miss_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output hit, rdata, busy, miss_count
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - 32-byte direct-mapped read cache over a byte backing store
// Loads hit combinationally; misses stall through a fixed-latency REFILL/FILL sequence.
module dmem_responder #(
  parameter int MEM_AW   = 8,
  parameter int MISS_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);
  localparam int DEPTH = 1 << MEM_AW;
  localparam int TW    = MEM_AW - 5;
  localparam int CW    = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_FILL
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [15:0]         r_miss_count;
  logic                r_busy;
  logic [MEM_AW-1:2]   r_fill_addr;
  logic [7:0]          r_valid;
  logic [TW-1:0]       r_tag  [8];
  logic [7:0]          r_data [8][4];
  logic [7:0]          r_mem  [DEPTH];

  logic [1:0]          w_off;
  logic [2:0]          w_index;
  logic [TW-1:0]       w_tag;
  logic                w_line_hit;
  logic                w_idle_req;
  logic [2:0]          w_fill_index;
  logic [TW-1:0]       w_fill_tag;
  logic                w_unused_addr;

  assign w_off        = bus.req_addr[1:0];
  assign w_index      = bus.req_addr[4:2];
  assign w_tag        = bus.req_addr[MEM_AW-1:5];
  assign w_line_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_idle_req   = bus.req_valid && (r_state == ST_IDLE);
  assign w_fill_index = r_fill_addr[4:2];
  assign w_fill_tag   = r_fill_addr[MEM_AW-1:5];
  // High address bits alias onto the backing store and are deliberately dropped.
  assign w_unused_addr = ^bus.req_addr[31:MEM_AW];

  assign bus.hit        = w_idle_req && (bus.req_we || w_line_hit);
  assign bus.rdata      = (w_idle_req && !bus.req_we && w_line_hit) ? r_data[w_index][w_off] : 8'h00;
  assign bus.busy       = r_busy;
  assign bus.miss_count = r_miss_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_miss_count <= '0;
      r_busy       <= 1'b0;
      r_fill_addr  <= '0;
      r_valid      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= i[7:0];
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_we) begin
            // Write-through; no allocation when the line is absent.
            r_mem[bus.req_addr[MEM_AW-1:0]] <= bus.req_wdata;
            if (w_line_hit) begin
              r_data[w_index][w_off] <= bus.req_wdata;
            end
          end else if (bus.req_valid && !w_line_hit) begin
            r_fill_addr  <= bus.req_addr[MEM_AW-1:2];
            r_cnt        <= CW'(MISS_LAT - 1);
            r_miss_count <= r_miss_count + 16'd1;
            r_busy       <= 1'b1;
            r_state      <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (r_cnt == '0) begin
            r_state <= ST_FILL;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_FILL: begin
          for (int k = 0; k < 4; k++) begin
            r_data[w_fill_index][k] <= r_mem[{r_fill_addr, 2'(k)}];
          end
          r_tag[w_fill_index]   <= w_fill_tag;
          r_valid[w_fill_index] <= 1'b1;
          r_busy                <= 1'b0;
          r_state               <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
